// File: rtl/regfile_wb_ctrl_if.sv
// Writeback controller bus: two writeback requesters, issue-stage reservation
// and hazard lookup, scoreboard view and the register-file write port.
interface regfile_wb_ctrl_if #(
    parameter int unsigned ADDR_SIZE     = 5,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_REGISTERS = 32
);
    // requester 0: ALU
    logic                     req0_valid;
    logic [ADDR_SIZE-1:0]     req0_addr;
    logic [XLEN-1:0]          req0_data;
    logic                     req0_ready;

    // requester 1: load/store unit
    logic                     req1_valid;
    logic [ADDR_SIZE-1:0]     req1_addr;
    logic [XLEN-1:0]          req1_data;
    logic                     req1_ready;

    // issue-stage reservation and hazard lookup
    logic                     rsv_valid;
    logic [ADDR_SIZE-1:0]     rsv_addr;
    logic [ADDR_SIZE-1:0]     rs1_addr;
    logic [ADDR_SIZE-1:0]     rs2_addr;
    logic                     rs1_busy;
    logic                     rs2_busy;

    // pipeline control and scoreboard view
    logic                     flush;
    logic [NUM_REGISTERS-1:0] busy;

    // register-file write port
    logic                     write_enable;
    logic [ADDR_SIZE-1:0]     write_addr;
    logic [XLEN-1:0]          write_data;

    // Requesters, issue stage and register file side
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output rsv_valid, rsv_addr, rs1_addr, rs2_addr, flush,
        input  rs1_busy, rs2_busy, busy,
        input  write_enable, write_addr, write_data
    );

    // Writeback controller side
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  rsv_valid, rsv_addr, rs1_addr, rs2_addr, flush,
        output rs1_busy, rs2_busy, busy,
        output write_enable, write_addr, write_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: round-robin merge of ALU and LSU writebacks onto the
// single register-file write port, plus the RAW busy scoreboard.
module regfile_wb_ctrl #(
    parameter int unsigned ADDR_SIZE     = 5,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NUM_REGISTERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_ctrl_if.slave bus
);
    localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = '0;

    // arbitration (combinational)
    logic                     grant_valid_c;
    logic                     grant_idx_c;
    logic                     xfer_c;
    logic [ADDR_SIZE-1:0]     sel_addr_c;
    logic [XLEN-1:0]          sel_data_c;

    // round-robin pointer: last granted requester
    logic                     rr_last_q;
    logic                     rr_last_d;

    // write stage
    logic                     write_enable_q;
    logic                     write_enable_d;
    logic [ADDR_SIZE-1:0]     write_addr_q;
    logic [ADDR_SIZE-1:0]     write_addr_d;
    logic [XLEN-1:0]          write_data_q;
    logic [XLEN-1:0]          write_data_d;

    // scoreboard
    logic [NUM_REGISTERS-1:0] busy_q;
    logic [NUM_REGISTERS-1:0] busy_d;

    // Pick a winner; on conflict the requester not granted last time wins.
    // Flush and reset suppress the grant so nothing is accepted.
    always_comb begin
        grant_valid_c = bus.req0_valid | bus.req1_valid;
        grant_idx_c   = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_idx_c = ~rr_last_q;
        end else if (bus.req1_valid) begin
            grant_idx_c = 1'b1;
        end
        xfer_c     = grant_valid_c && !bus.flush && !rst;
        sel_addr_c = grant_idx_c ? bus.req1_addr : bus.req0_addr;
        sel_data_c = grant_idx_c ? bus.req1_data : bus.req0_data;
    end

    assign bus.req0_ready = xfer_c && !grant_idx_c;
    assign bus.req1_ready = xfer_c &&  grant_idx_c;

    // Pointer follows the granted index only when a transfer happens.
    always_comb begin
        rr_last_d = rr_last_q;
        if (xfer_c) begin
            rr_last_d = grant_idx_c;
        end
    end

    // Register the accepted write; x0 writes are accepted but never enabled.
    always_comb begin
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        if (xfer_c) begin
            write_enable_d = (sel_addr_c != ZERO_ADDR);
            write_addr_d   = sel_addr_c;
            write_data_d   = sel_data_c;
        end
    end

    // Scoreboard update: clear on write, set on reservation (newer wins),
    // flush clears everything, x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (bus.rsv_valid && (bus.rsv_addr != ZERO_ADDR)) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q      <= 1'b1;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
        end else begin
            rr_last_q      <= rr_last_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            busy_q         <= busy_d;
        end
    end

    // Hazard lookup is a direct read of the current bitmap.
    assign bus.rs1_busy = (bus.rs1_addr != ZERO_ADDR) && busy_q[bus.rs1_addr];
    assign bus.rs2_busy = (bus.rs2_addr != ZERO_ADDR) && busy_q[bus.rs2_addr];

    assign bus.busy         = busy_q;
    assign bus.write_enable = write_enable_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for the writeback controller with hand-computed expectations.
module tb_regfile_wb_ctrl;
    localparam int unsigned ADDR_SIZE     = 5;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned NUM_REGISTERS = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    regfile_wb_ctrl_if #(
        .ADDR_SIZE(ADDR_SIZE), .XLEN(XLEN), .NUM_REGISTERS(NUM_REGISTERS)
    ) bus ();

    regfile_wb_ctrl #(
        .ADDR_SIZE(ADDR_SIZE), .XLEN(XLEN), .NUM_REGISTERS(NUM_REGISTERS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to 2 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsv_valid  = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic reserve(input logic [4:0] a);
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = a;
        tick();
        bus.rsv_valid = 1'b0;
    endtask

    logic exp_r0 [4];
    logic [4:0] exp_wa [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_r0 = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_wa = '{5'd0, 5'd3, 5'd4, 5'd3};

        rst = 1'b0;
        idle();
        bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_addr = '0; bus.req1_data = '0;
        bus.rsv_addr  = '0;
        bus.rs1_addr  = '0; bus.rs2_addr = '0;
        #1 rst = 1'b1;
        #6;

        // reset state
        chk("rst_we",   32'(bus.write_enable), 32'd0);
        chk("rst_wa",   32'(bus.write_addr),   32'd0);
        chk("rst_wd",   bus.write_data,        32'd0);
        chk("rst_busy", bus.busy,              32'd0);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h22;
        settle();
        chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
        chk("rst_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        rst = 1'b0;
        settle();

        // round-robin with both requesters held valid
        for (int i = 0; i < 4; i++) begin
            chk("rr_rdy0", 32'(bus.req0_ready), 32'(exp_r0[i]));
            chk("rr_rdy1", 32'(bus.req1_ready), 32'(!exp_r0[i]));
            if (i > 0) begin
                chk("rr_we", 32'(bus.write_enable), 32'd1);
                chk("rr_wa", 32'(bus.write_addr),   32'(exp_wa[i]));
            end
            tick();
        end
        idle();
        chk("rr_last_we", 32'(bus.write_enable), 32'd1);
        chk("rr_last_wa", 32'(bus.write_addr),   32'd4);
        chk("rr_last_wd", bus.write_data,        32'h22);
        tick();
        chk("rr_idle_we", 32'(bus.write_enable), 32'd0);
        chk("rr_hold_wa", 32'(bus.write_addr),   32'd4);

        // x0 write is accepted then dropped
        reserve(5'd9);
        chk("x0_pre_busy", bus.busy, 32'h200);
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hDEADBEEF;
        settle();
        chk("x0_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        chk("x0_we",   32'(bus.write_enable), 32'd0);
        chk("x0_busy", bus.busy,              32'h200);
        tick();
        chk("x0_busy2", bus.busy, 32'h200);

        // scoreboard lifecycle on x5
        reserve(5'd5);
        bus.rs1_addr = 5'd5;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h55;
        settle();
        chk("sb_rs1_busy0", 32'(bus.rs1_busy),   32'd1);
        chk("sb_rdy0",      32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        chk("sb_we",        32'(bus.write_enable), 32'd1);
        chk("sb_wa",        32'(bus.write_addr),   32'd5);
        chk("sb_wd",        bus.write_data,        32'h55);
        chk("sb_rs1_busy1", 32'(bus.rs1_busy),     32'd1);
        tick();
        chk("sb_rs1_clear", 32'(bus.rs1_busy), 32'd0);
        chk("sb_busy",      bus.busy,          32'h200);
        bus.rs2_addr = 5'd9;
        bus.rs1_addr = 5'd0;
        settle();
        chk("sb_rs2_busy",  32'(bus.rs2_busy), 32'd1);
        chk("sb_rs1_x0",    32'(bus.rs1_busy), 32'd0);

        // simultaneous set and clear of x7: set wins
        reserve(5'd7);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
        settle();
        chk("sc_rdy0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
        chk("sc_we", 32'(bus.write_enable), 32'd1);
        chk("sc_wa", 32'(bus.write_addr),   32'd7);
        tick();
        bus.rsv_valid = 1'b0;
        chk("sc_busy", bus.busy, 32'h280);
        reserve(5'd0);
        chk("sc_x0_busy", bus.busy, 32'h280);

        // flush clears scoreboard, blocks grant, lets issued write finish
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_clear", bus.busy, 32'h0);
        reserve(5'd8);
        reserve(5'd9);
        reserve(5'd10);
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd11;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd12; bus.req1_data = 32'hCC;
        settle();
        chk("fl_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.rsv_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("fl_busy_pre", bus.busy,              32'hF00);
        chk("fl_we_pre",   32'(bus.write_enable), 32'd1);
        chk("fl_wa_pre",   32'(bus.write_addr),   32'd12);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h33;
        bus.flush = 1'b1;
        settle();
        chk("fl_rdy0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        settle();
        chk("fl_busy_post", bus.busy,              32'h0);
        chk("fl_we_post",   32'(bus.write_enable), 32'd0);
        chk("fl_rdy0_after",32'(bus.req0_ready),   32'd1);
        tick();
        bus.req0_valid = 1'b0;
        chk("fl_late_we", 32'(bus.write_enable), 32'd1);
        chk("fl_late_wa", 32'(bus.write_addr),   32'd3);
        chk("fl_late_wd", bus.write_data,        32'h33);
        tick();

        // reset mid-cycle with a live write and busy = 0xF0
        reserve(5'd4);
        reserve(5'd5);
        reserve(5'd6);
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'h2A;
        tick();
        bus.rsv_valid = 1'b0; bus.req0_valid = 1'b0;
        chk("mr_busy_pre", bus.busy,              32'hF0);
        chk("mr_we_pre",   32'(bus.write_enable), 32'd1);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h22;
        #1 rst = 1'b1;
        #1;
        chk("mr_we",   32'(bus.write_enable), 32'd0);
        chk("mr_wa",   32'(bus.write_addr),   32'd0);
        chk("mr_wd",   bus.write_data,        32'd0);
        chk("mr_busy", bus.busy,              32'd0);
        chk("mr_rdy0", 32'(bus.req0_ready),   32'd0);
        chk("mr_rdy1", 32'(bus.req1_ready),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("mr_first_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("mr_first_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        idle();
        chk("mr_first_we", 32'(bus.write_enable), 32'd1);
        chk("mr_first_wa", 32'(bus.write_addr),   32'd3);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller for the 32-entry register file. It merges two writeback requesters onto the single register-file write port: requester 0 is the ALU and requester 1 is the load/store unit. Each requester uses a valid/ready handshake and the two are arbitrated round-robin. The block also keeps a busy scoreboard of destination registers that have been reserved at issue but not yet written, and the issue stage uses it for RAW hazard stalls.

## Interface
- ADDR_SIZE, 5: register address width (32 registers)
- XLEN, 32: data width
- NUM_REGISTERS, 32: scoreboard depth, equal to 2**ADDR_SIZE
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  ALU writeback request
- req0_addr  in  ADDR_SIZE  ALU destination register
- req0_data  in  XLEN  ALU result
- req0_ready  out  1  ALU request granted this cycle
- req1_valid / req1_addr / req1_data / req1_ready: same as above, for the LSU
- rsv_valid  in  1  issue stage reserves a destination register
- rsv_addr  in  ADDR_SIZE  register to reserve
- rs1_addr, rs2_addr  in  ADDR_SIZE  source registers for the hazard lookup
- rs1_busy, rs2_busy  out  1  source register has a pending write (combinational)
- flush  in  1  pipeline flush; clears the scoreboard
- busy  out  NUM_REGISTERS  scoreboard bitmap; bit 0 is always 0
- write_enable  out  1  to the register-file write port
- write_addr  out  ADDR_SIZE  to the register-file write port
- write_data  out  XLEN  to the register-file write port

## Operation
**Arbitration**
- `rr_last` is a 1-bit pointer to the last granted requester. Reset value is 1, so requester 0 wins the first conflict.
- Only req0 valid: grant 0. Only req1 valid: grant 1.
- Both valid: grant the requester not equal to `rr_last`.
- Neither valid: no grant, and `rr_last` holds.
- `reqN_ready` = grant to N (combinational) and not flush.
- A transfer is `reqN_valid && reqN_ready`. At most one transfer per cycle.
- On a transfer, `rr_last` takes the granted index.
- Requesters hold addr and data stable while valid and not ready. Neither requester can be starved for more than 1 cycle of conflict.

**Write stage**
- On a transfer, register the write-port outputs for the next cycle: `write_enable` = (addr != 0), plus `write_addr` and `write_data`.
- With no transfer, `write_enable` is 0 next cycle. `write_addr` and `write_data` hold their previous values.
- A write to x0 is accepted (ready asserted), then dropped. It never asserts `write_enable`.

**Scoreboard**
- A rising edge with `write_enable`=1 clears `busy[write_addr]`. This is the same edge at which the register file captures the data.
- A rising edge with `rsv_valid`=1 and `rsv_addr`!=0 sets `busy[rsv_addr]`.
- If the set and clear target the same register on one edge, the set wins (the newer reservation).
- `flush`=1 at an edge clears all busy bits. This overrides both set and clear.
- A `write_enable` already issued still completes during a flush.
- `busy[0]` is always 0. A reservation of x0 is ignored.
- A write to a non-busy register is legal and leaves the scoreboard unchanged.
- `rs1_busy` = `busy[rs1_addr]` and `rs2_busy` = `busy[rs2_addr]`. Both are pure combinational reads of the current bitmap, and both are 0 for address 0.

## Timing
- Reset is asynchronous and takes effect immediately. Reset values:
  - `write_enable`=0, `write_addr`=0, `write_data`=0
  - `busy`=0, `rr_last`=1
  - `reqN_ready`=0 while rst is high
- Grant latency is 0 cycles: ready is asserted in the same cycle as valid when that requester wins.
- Request-to-write latency is 1 cycle: `write_enable` is high in the cycle after the transfer.
- Busy clear: the `busy` bit drops at the edge ending the `write_enable` cycle. It is therefore 0 two cycles after the transfer edge.
- Throughput is one write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1.
- Reset asserted mid-operation discards any pending write. `write_enable` drops asynchronously and no further register-file write is issued.

## Test plan
- **Reset.** Assert rst mid-cycle with `write_enable`=1 and `busy`=0x0000_00F0.
  - All outputs go to 0 immediately.
  - After release, a simultaneous req0/req1 grants req0 first.
- **Round-robin.** Hold req0 (addr 3, data 0x11) and req1 (addr 4, data 0x22) valid for 4 cycles.
  - Grants go 0,1,0,1.
  - `write_addr` sequence is 3,4,3,4, each one cycle after its grant.
- **x0 drop.** req1_valid with addr 0 and data 0xDEADBEEF.
  - `req1_ready`=1.
  - `write_enable` stays 0 the next cycle.
  - `busy` is unchanged.
- **Scoreboard lifecycle.** Reserve x5. Then, the following cycle, assert `rs1_addr`=5 and send req0 with addr 5, data 0x55.
  - `rs1_busy`=1 until the edge ending the `write_enable` cycle, then 0.
  - `write_data`=0x55.
- **Simultaneous set/clear.** In the `write_enable` cycle for x7, also `rsv_valid` with addr 7.
  - `busy[7]` remains 1.
  - Separately, reserving x0 leaves `busy[0]`=0.
- **Flush.** Set `busy` to 0x0000_0F00, a pending req0 is valid, and `flush`=1.
  - `req0_ready`=0 that cycle.
  - `busy`=0 after the edge.
  - The already-issued `write_enable` still completes.
